// File: rtl/rv32v_types_pkg.sv
// Shared vector-unit types: lane geometry, element width, and the writeback beat record
// carried from the execute/memory stages to the register-file write port.
package rv32v_types_pkg;

  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 5;

  typedef logic [31:0]         word_t;
  typedef logic [VL_WIDTH-1:0] offset_t;
  typedef logic [VL_WIDTH:0]   vl_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_t;

  typedef struct packed {
    word_t [NUM_LANES-1:0] data;
    logic  [NUM_LANES-1:0] lane_en;
    logic  [4:0]           vd;
    sew_t                  eew;
    vl_t                   vl;
    logic                  single_bit;
    logic                  first;
  } wb_beat_t;

endpackage

// File: rtl/rv32v_wb_fifo.sv
// Synchronous FIFO of writeback beats with full/empty flags and occupancy count.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module rv32v_wb_fifo
  import rv32v_types_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_beat_t
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clear,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rd_en    = pop & ~empty & ~clear;
  assign wr_en    = push & (~full | rd_en) & ~clear;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32v_wb_sequencer.sv
// Vector RF writeback sequencer: buffers lane-result beats, tracks the element offset
// within an instruction, masks tail/inactive lanes and pulses done on the last write.
module rv32v_wb_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic [NUM_LANES*32-1:0]   in_data,
  input  logic [NUM_LANES-1:0]      in_lane_en,
  input  logic [4:0]                in_vd,
  input  sew_t                      in_eew,
  input  vl_t                       in_vl,
  input  logic                      in_single_bit,
  input  logic                      stall,
  input  logic                      flush,
  output logic [NUM_LANES*32-1:0]   w_data,
  output logic [4:0]                vd,
  output logic [NUM_LANES-1:0]      wen,
  output offset_t                   vd_offset,
  output sew_t                      eew,
  output vl_t                       vl,
  output logic                      single_bit_write,
  output logic                      done,
  output logic                      proto_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t             state;
  vl_t                   offset;
  wb_beat_t              push_beat;
  wb_beat_t              head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  push;
  logic                  pop;

  logic                  restart;
  logic                  bad_seq;
  logic                  last;
  vl_t                   base;
  vl_t                   next_base;
  logic [NUM_LANES-1:0]  beat_wen;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = ~fifo_empty & ~stall & ~flush;

  always_comb begin
    push_beat            = '0;
    push_beat.data       = in_data;
    push_beat.lane_en    = in_lane_en;
    push_beat.vd         = in_vd;
    push_beat.eew        = in_eew;
    push_beat.vl         = in_vl;
    push_beat.single_bit = in_single_bit;
    push_beat.first      = in_first;
  end

  rv32v_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_beat_t)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (flush),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A non-first beat arriving while idle is treated as if it started a new instruction.
  always_comb begin
    restart   = head.first | (state == IDLE);
    bad_seq   = head.first == (state == ACTIVE);
    base      = restart ? '0 : offset;
    next_base = base + vl_t'(NUM_LANES);
    last      = (next_base >= head.vl);
    beat_wen  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      beat_wen[i] = head.lane_en[i] & ((base + vl_t'(i)) < head.vl);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      offset           <= '0;
      w_data           <= '0;
      vd               <= '0;
      wen              <= '0;
      vd_offset        <= '0;
      eew              <= SEW_8;
      vl               <= '0;
      single_bit_write <= 1'b0;
      done             <= 1'b0;
      proto_err        <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      offset <= '0;
      wen    <= '0;
      done   <= 1'b0;
    end else if (pop) begin
      w_data           <= head.data;
      vd               <= head.vd;
      eew              <= head.eew;
      vl               <= head.vl;
      single_bit_write <= head.single_bit;
      wen              <= beat_wen;
      vd_offset        <= base[VL_WIDTH-1:0];
      done             <= last;
      state            <= last ? IDLE : ACTIVE;
      offset           <= last ? '0 : next_base;
      if (bad_seq) proto_err <= 1'b1;
    end else begin
      wen  <= '0;
      done <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) assert (fifo_count <= CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_rv32v_wb_sequencer.sv
// Self-checking bench for rv32v_wb_sequencer: directed vector table, hand-written
// stall/flush/protocol sequences and a randomized run against an element-count model.
module tb_rv32v_wb_sequencer;
  import rv32v_types_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int NL = NUM_LANES;

  logic                CLK = 1'b0;
  logic                RST;
  logic                in_valid;
  logic                in_ready;
  logic                in_first;
  logic [NL*32-1:0]    in_data;
  logic [NL-1:0]       in_lane_en;
  logic [4:0]          in_vd;
  sew_t                in_eew;
  vl_t                 in_vl;
  logic                in_single_bit;
  logic                stall;
  logic                flush;
  logic [NL*32-1:0]    w_data;
  logic [4:0]          vd;
  logic [NL-1:0]       wen;
  offset_t             vd_offset;
  sew_t                eew;
  vl_t                 vl;
  logic                single_bit_write;
  logic                done;
  logic                proto_err;

  rv32v_wb_sequencer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_data(in_data), .in_lane_en(in_lane_en), .in_vd(in_vd), .in_eew(in_eew),
    .in_vl(in_vl), .in_single_bit(in_single_bit), .stall(stall), .flush(flush),
    .w_data(w_data), .vd(vd), .wen(wen), .vd_offset(vd_offset), .eew(eew), .vl(vl),
    .single_bit_write(single_bit_write), .done(done), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic            first;
    logic [NL-1:0]   lane_en;
    int              vl;
    logic [NL*32-1:0] data;
    logic [4:0]      vd;
    logic [1:0]      eew;
    logic            sb;
  } beat_s;

  typedef struct {
    logic          first;
    logic [NL-1:0] lane_en;
    int            vl;
    logic [NL-1:0] exp_wen;
    int            exp_off;
    logic          exp_done;
  } vec_s;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;

  beat_s q[$];
  bit    m_active;
  int    m_idx;
  logic [NL-1:0]    e_wen;
  logic             e_done;
  logic [NL*32-1:0] e_data;
  logic [4:0]       e_vd;
  logic [1:0]       e_eew;
  int               e_vl;
  logic             e_sb;
  int               e_off;
  logic             e_perr;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_idx = 0;
    e_wen = '0; e_done = 0; e_data = '0; e_vd = '0; e_eew = '0;
    e_vl = 0; e_sb = 0; e_off = 0; e_perr = 0;
  endtask

  // Model counts elements already written for the current instruction.
  task automatic model_step();
    beat_s b;
    int    base;
    bit    acc;
    acc = in_valid && (q.size() < FIFO_DEPTH);
    if (RST) begin
      model_reset();
    end else if (flush) begin
      q.delete();
      m_active = 0; m_idx = 0; e_wen = '0; e_done = 0;
    end else begin
      if (q.size() > 0 && !stall) begin
        b = q.pop_front();
        if (b.first == m_active) e_perr = 1;
        base = (b.first || !m_active) ? 0 : m_idx;
        for (int i = 0; i < NL; i++) e_wen[i] = b.lane_en[i] && (base + i < b.vl);
        e_done   = (base + NL >= b.vl);
        m_active = !e_done;
        m_idx    = e_done ? 0 : base + NL;
        e_off = base; e_data = b.data; e_vd = b.vd; e_eew = b.eew; e_vl = b.vl; e_sb = b.sb;
      end else begin
        e_wen = '0; e_done = 0;
      end
      if (acc) begin
        b.first = in_first; b.lane_en = in_lane_en; b.vl = int'(in_vl); b.data = in_data;
        b.vd = in_vd; b.eew = in_eew; b.sb = in_single_bit;
        q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    check("in_ready", in_ready, q.size() < FIFO_DEPTH);
    model_step();
    @(posedge CLK);
    #1;
    if (wen !== '0) nwr++;
    check("wen", wen, e_wen);
    check("done", done, e_done);
    check("vd_offset", vd_offset, e_off % (1 << VL_WIDTH));
    check("w_data", w_data, e_data);
    check("vd", vd, e_vd);
    check("eew", eew, e_eew);
    check("vl", vl, e_vl);
    check("single_bit_write", single_bit_write, e_sb);
    check("proto_err", proto_err, e_perr);
  endtask

  task automatic drive(input logic first, input logic [NL-1:0] len, input int v,
                       input logic [NL*32-1:0] d);
    in_valid = 1; in_first = first; in_lane_en = len; in_vl = vl_t'(v); in_data = d;
    in_vd = 5'd7; in_eew = SEW_32; in_single_bit = 0;
  endtask

  task automatic send(input logic first, input logic [NL-1:0] len, input int v,
                      input logic [NL*32-1:0] d);
    bit acc;
    acc = 0;
    drive(first, len, v, d);
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) begin
      bad++; total++;
      $display("FAIL send_timeout: got not-accepted expected accepted at %0t", $time);
    end
    in_valid = 0;
  endtask

  vec_s vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gen_left, gen_vl;
    logic gen_first;
    bit acc;

    vecs[0] = '{1, 2'b11, 5, 2'b11, 0, 0};
    vecs[1] = '{0, 2'b11, 5, 2'b11, 2, 0};
    vecs[2] = '{0, 2'b11, 5, 2'b01, 4, 1};
    vecs[3] = '{1, 2'b10, 4, 2'b10, 0, 0};
    vecs[4] = '{0, 2'b11, 4, 2'b11, 2, 1};
    vecs[5] = '{1, 2'b11, 0, 2'b00, 0, 1};

    RST = 1; in_valid = 0; in_first = 0; in_data = '0; in_lane_en = '0; in_vd = '0;
    in_eew = SEW_8; in_vl = '0; in_single_bit = 0; stall = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    tick();
    RST = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_wen", wen, 0);
    check("rst_w_data", w_data, 0);
    check("rst_proto_err", proto_err, 0);

    for (int k = 0; k < 6; k++) begin
      send(vecs[k].first, vecs[k].lane_en, vecs[k].vl, {32'(k), 32'hC0DE_0000 + 32'(k)});
      tick();
      check("tbl_wen", wen, vecs[k].exp_wen);
      check("tbl_off", vd_offset, vecs[k].exp_off);
      check("tbl_done", done, vecs[k].exp_done);
    end
    tick();
    check("vl0_idle_wen", wen, 0);

    // Stall fills the buffer; releasing it must drain all six beats in order.
    nwr = 0;
    stall = 1;
    for (int k = 0; k < 4; k++) send(k == 0, 2'b11, 12, 64'hA0 + 64'(k));
    check("stall_full_ready", in_ready, 0);
    drive(0, 2'b11, 12, 64'hA4);
    tick(); tick();
    check("stall_still_full", in_ready, 0);
    stall = 0;
    send(0, 2'b11, 12, 64'hA4);
    send(0, 2'b11, 12, 64'hA5);
    repeat (8) tick();
    check("stall_nwr", nwr, 6);

    // Flush with two beats written and two buffered.
    stall = 1;
    for (int k = 0; k < 4; k++) send(k == 0, 2'b11, 8, 64'hB0 + 64'(k));
    stall = 0;
    tick(); tick();
    check("pre_flush_off", vd_offset, 2);
    flush = 1;
    drive(1, 2'b11, 8, 64'hDEAD);
    tick();
    flush = 0; in_valid = 0;
    check("flush_wen", wen, 0);
    check("flush_done", done, 0);
    check("flush_empty", in_ready, 1);
    nwr = 0;
    repeat (3) tick();
    check("flush_no_writes", nwr, 0);
    send(1, 2'b11, 4, 64'hE0);
    tick();
    check("post_flush_wen", wen, 2'b11);
    check("post_flush_off", vd_offset, 0);
    tick();

    // First beat arriving mid-instruction.
    send(1, 2'b11, 8, 64'hF0);
    tick();
    send(1, 2'b11, 8, 64'hF1);
    tick();
    check("perr_set", proto_err, 1);
    check("perr_off", vd_offset, 0);
    send(0, 2'b11, 8, 64'hF2);
    tick();
    check("perr_next_off", vd_offset, 2);
    repeat (2) tick();
    check("perr_sticky", proto_err, 1);
    RST = 1;
    tick();
    RST = 0;
    check("perr_rst", proto_err, 0);
    check("rst2_wen", wen, 0);

    gen_left = 0; gen_vl = 0; gen_first = 1;
    for (int c = 0; c < 3000; c++) begin
      if (gen_left == 0) begin
        gen_vl    = $urandom_range(0, 1 << VL_WIDTH);
        gen_left  = (gen_vl + NL - 1) / NL;
        if (gen_left == 0) gen_left = 1;
        gen_first = 1;
      end
      stall         = ($urandom % 4) == 0;
      flush         = ($urandom % 64) == 0;
      in_valid      = ($urandom % 3) != 0;
      in_first      = gen_first ^ (($urandom % 20) == 0);
      in_vl         = vl_t'(gen_vl);
      in_lane_en    = NL'($urandom);
      in_data       = {$urandom, $urandom};
      in_vd         = 5'($urandom);
      in_eew        = sew_t'(2'($urandom));
      in_single_bit = 1'($urandom);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        gen_left--;
        gen_first = 0;
      end
    end
    in_valid = 0; stall = 0; flush = 0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
